// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Four-channel debouncer for active-low mechanical push buttons.
//            Each raw input is synchronised with two flip-flops. A per-button
//            counter accepts a new level only after DEBOUNCE_CYCLES
//            consecutive cycles in which the synchronised value differs
//            from the accepted level. A one-cycle press strobe fires when a
//            button becomes pressed.
//            Optional feature: define BTN_TOGGLE_EN to add a per-button
//            toggle flop that flips one cycle after each press strobe.
//            Without the macro, TOGGLE is tied low and has no flops.
// Ports    : clk                  system clock, rising edge
//            rst                  asynchronous reset, active-high
//            BOTON0..BOTON3       raw buttons, active-low, asynchronous
//            BTN0..BTN3           debounced levels, active-low
//            PRESS[3:0]           one-cycle press strobes, active-high
//            TOGGLE[3:0]          per-button toggle state (0 when disabled)
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BOTON0,
    input  logic       BOTON1,
    input  logic       BOTON2,
    input  logic       BOTON3,
    output logic       BTN0,
    output logic       BTN1,
    output logic       BTN2,
    output logic       BTN3,
    output logic [3:0] PRESS,
    output logic [3:0] TOGGLE
);

    localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] w_boton;
    logic [3:0] w_state;
    logic [3:0] w_press;
    logic [3:0] w_toggle;

    assign w_boton = {BOTON3, BOTON2, BOTON1, BOTON0};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             state_q;
            logic             state_d;
            logic             press_q;
            logic             press_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Any cycle where the synchronised level matches the accepted
            // level clears the count, so a glitch must persist for
            // DEBOUNCE_CYCLES uninterrupted cycles to be accepted.
            always_comb begin
                state_d = state_q;
                cnt_d   = '0;
                press_d = 1'b0;
                if (sync2_q == state_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = sync2_q;
                    cnt_d   = '0;
                    // Only a 1->0 acceptance is a press; releases are silent.
                    press_d = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // The press strobe is registered on the same edge as the state,
            // so it is high in exactly the first cycle the button reads low.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    state_q <= 1'b1;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    sync1_q <= w_boton[gi];
                    sync2_q <= sync1_q;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end

            assign w_state[gi] = state_q;
            assign w_press[gi] = press_q;

`ifdef BTN_TOGGLE_EN
            logic toggle_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    toggle_q <= 1'b0;
                end else begin
                    toggle_q <= toggle_q ^ press_q;
                end
            end

            assign w_toggle[gi] = toggle_q;
`else
            assign w_toggle[gi] = 1'b0;
`endif
        end
    endgenerate

    assign BTN0   = w_state[0];
    assign BTN1   = w_state[1];
    assign BTN2   = w_state[2];
    assign BTN3   = w_state[3];
    assign PRESS  = w_press;
    assign TOGGLE = w_toggle;

endmodule
`default_nettype wire

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 12000, number of consecutive stable clk cycles required to accept a new button level (1 ms at 12 MHz); legal range 2..65535.
REQ-002 clk  input  1  system clock, rising-edge active, one clock domain for the whole block.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 BOTON0..BOTON3  input  1 each  raw mechanical buttons, active-low (1 = released), asynchronous to clk.
REQ-005 BTN0..BTN3  output  1 each  debounced button levels, active-low; these drive the BOTON0..BOTON3 inputs of the downstream LED stage.
REQ-006 PRESS  output  4  one-cycle press strobes, bit i for button i, active-high.
REQ-007 TOGGLE  output  4  per-button toggle state, bit i for button i (see Configuration).

Function
REQ-008 Each BOTONi shall pass through a 2-flip-flop synchronizer before any other use; the output of the second stage is syncI.
REQ-009 Each button shall have an independent stable-state register stateI and counter cntI, each cntI ceil(log2(DEBOUNCE_CYCLES)) bits wide; BTNi shall equal stateI.
REQ-010 Per cycle: if syncI == stateI, cntI <= 0.
REQ-011 Per cycle: else if cntI == DEBOUNCE_CYCLES-1, stateI <= syncI and cntI <= 0.
REQ-012 Per cycle: else cntI <= cntI+1; the counter shall never wrap.
REQ-013 Any cycle in which syncI returns to stateI before acceptance shall clear cntI (glitch rejection); a glitch of DEBOUNCE_CYCLES-1 cycles or fewer at syncI shall never change BTNi.
REQ-014 Latency: a clean level change on BOTONi held indefinitely shall appear on BTNi exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-015 PRESS[i] shall be a registered signal, high for exactly one cycle, in the same cycle that BTNi first reads 0 after a 1->0 transition of stateI; a release (0->1) shall not assert PRESS.
REQ-016 Buttons shall be fully independent: simultaneous changes on several buttons shall be debounced in parallel, and several PRESS bits may be high in the same cycle.
REQ-017 No combinational path shall exist from any BOTONi to any output.

Reset
REQ-018 While rst is high: synchronizer flops = 1, stateI = 1 (BTN0..BTN3 = 1, released), cntI = 0, PRESS = 4'b0000, TOGGLE = 4'b0000.
REQ-019 Reset asserted mid-debounce shall discard the pending count; after release, a button still held low shall be re-debounced from zero and shall then produce one PRESS pulse.
REQ-020 No PRESS pulse shall be generated by reset assertion or deassertion itself.

Configuration
REQ-021 Macro BTN_TOGGLE_EN: when defined, TOGGLE[i] shall invert in the cycle after each PRESS[i] pulse (registered from PRESS[i]) and reset to 0.
REQ-022 Without BTN_TOGGLE_EN, the TOGGLE port shall remain present and be tied to 4'b0000, and no toggle flops shall be synthesized; all other behaviour shall be identical.

Verification (DEBOUNCE_CYCLES=4 in bench)
REQ-023 rst=1 for 3 cycles, all BOTON=1, then release -> BTN0..3=1, PRESS=0, TOGGLE=0 at every cycle of reset and after.
REQ-024 BOTON0 1->0 held -> BTN0 falls exactly 6 edges later, PRESS=4'b0001 for one cycle coincident with the fall; BOTON0 0->1 -> BTN0 rises 6 edges later, with no PRESS pulse.
REQ-025 BOTON1 pulsed low for 3 cycles then high, repeated 5 times -> BTN1 stays 1 and PRESS stays 0 throughout.
REQ-026 BOTON2 and BOTON3 fall on the same edge -> BTN2 and BTN3 fall on the same cycle, and PRESS=4'b1100 for one cycle.
REQ-027 BOTON0 low, rst pulsed at count 2 -> BTN0 stays 1 during reset; after release BTN0 falls 6 edges later with one PRESS[0] pulse.
REQ-028 With BTN_TOGGLE_EN, three BOTON1 presses -> TOGGLE[1] sequence 1,0,1, each change occurring one cycle after its PRESS[1] pulse; without the macro, TOGGLE=0 throughout.
